prog_loader: RTL and testbench

Boot/program controller for the Mini-MIPS `Proc` core. It streams instruction words from a host into the core's instruction-memory write port at consecutive addresses. It then holds the core in reset-free idle for a settle interval and asserts `exec` to start execution. It sits between the host/debug interface and `Proc`'s `a`/`d`/`we`/`exec` inputs, and replaces hand-sequenced loading.

---
 rtl/proc_pkg.sv | 17 +
 rtl/prog_loader.sv | 247 ++++++++++++++++++++++++
 tb/tb_prog_loader.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the Mini-MIPS Proc core and its program loader.
//   IMEM_ADDR_W    : instruction-memory address width
//   WORD_W         : instruction word width
//   loader_state_t : prog_loader control states
package proc_pkg;

  localparam int IMEM_ADDR_W = 9;
  localparam int WORD_W      = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SETTLE = 2'd2,
    RUN    = 2'd3
  } loader_state_t;

endpackage : proc_pkg

// File: rtl/prog_loader.sv
// prog_loader: boot/program controller for the Mini-MIPS Proc core.
// Streams host words into the instruction-memory write port at consecutive
// addresses, waits a settle interval, then raises exec.
//
// Optional feature macro: PROG_LOADER_CHECKSUM_EN adds the `checksum` output
// (modulo-2^DATA_W sum of all words accepted in the current session).
//
// Ports:
//   clk, rst         : clock, asynchronous active-low reset
//   load_req         : one-cycle pulse starting a session (honoured in IDLE only)
//   base_addr        : first write address, sampled with load_req
//   word_count       : number of words to load, sampled with load_req (0 allowed)
//   in_valid/in_data : host word stream
//   in_ready         : loader accepts a word this cycle
//   halt             : abort a load / stop execution
//   mem_a/mem_d/mem_we/mem_exec : to Proc a/d/we/exec (all registered)
//   busy             : not IDLE
//   done             : one-cycle pulse on entry to RUN
//   err              : sticky range error from the last load_req
//   checksum         : (PROG_LOADER_CHECKSUM_EN only) running word sum
module prog_loader
  import proc_pkg::*;
#(
  parameter int ADDR_W        = IMEM_ADDR_W,
  parameter int DATA_W        = WORD_W,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              halt,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_d,
  output logic              mem_we,
  output logic              mem_exec,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef PROG_LOADER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  // Settle counter runs 0..SETTLE_CYCLES-1.
  localparam int                CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  // One past the last legal address, in a width that cannot overflow the check.
  localparam logic [ADDR_W+1:0] ADDR_SPAN = {2'b01, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   REM_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  loader_state_t     state_r, state_nx_s;
  logic [ADDR_W-1:0] addr_r, addr_nx_s;
  logic [ADDR_W:0]   rem_r, rem_nx_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nx_s;
  logic [ADDR_W-1:0] mem_a_r, mem_a_nx_s;
  logic [DATA_W-1:0] mem_d_r, mem_d_nx_s;
  logic              mem_we_r, mem_we_nx_s;
  logic              mem_exec_r, mem_exec_nx_s;
  logic              done_r, done_nx_s;
  logic              err_r, err_nx_s;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] csum_r, csum_nx_s;
`endif

  logic              in_ready_s;
  logic              hs_s;
  logic              range_err_s;
  logic              last_word_s;
  logic              settle_done_s;
  logic [ADDR_W+1:0] end_addr_s;

  // Handshake and decision terms shared by the next-state and output logic.
  always_comb begin
    in_ready_s    = (state_r == LOAD) && !halt;
    hs_s          = in_valid && in_ready_s;
    end_addr_s    = {2'b00, base_addr} + {1'b0, word_count};
    range_err_s   = (end_addr_s > ADDR_SPAN);
    last_word_s   = (rem_r == REM_ONE);
    // The first SETTLE cycle after a load still carries the final write;
    // only cycles with mem_we low count toward the settle interval.
    settle_done_s = (state_r == SETTLE) && !mem_we_r && (cnt_r == CNT_LAST);
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; halt wins over every other event.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (halt) begin
          state_nx_s = IDLE;
        end else if (load_req && !range_err_s) begin
          state_nx_s = (word_count == '0) ? SETTLE : LOAD;
        end else begin
          state_nx_s = IDLE;
        end
      end
      LOAD: begin
        if (halt) begin
          state_nx_s = IDLE;
        end else if (hs_s && last_word_s) begin
          state_nx_s = SETTLE;
        end else begin
          state_nx_s = LOAD;
        end
      end
      SETTLE: begin
        if (halt) begin
          state_nx_s = IDLE;
        end else if (settle_done_s) begin
          state_nx_s = RUN;
        end else begin
          state_nx_s = SETTLE;
        end
      end
      RUN: begin
        if (halt) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = RUN;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Output / datapath next values; all of these feed registers.
  always_comb begin
    addr_nx_s     = addr_r;
    rem_nx_s      = rem_r;
    cnt_nx_s      = '0;
    mem_a_nx_s    = mem_a_r;
    mem_d_nx_s    = mem_d_r;
    mem_we_nx_s   = 1'b0;
    mem_exec_nx_s = (state_nx_s == RUN);
    done_nx_s     = (state_r == SETTLE) && (state_nx_s == RUN);
    err_nx_s      = err_r;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_nx_s     = csum_r;
`endif
    case (state_r)
      IDLE: begin
        if (!halt && load_req) begin
          if (range_err_s) begin
            err_nx_s = 1'b1;
          end else begin
            err_nx_s  = 1'b0;
            addr_nx_s = base_addr;
            rem_nx_s  = word_count;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_nx_s = '0;
`endif
          end
        end else begin
          err_nx_s = err_r;
        end
      end
      LOAD: begin
        if (hs_s) begin
          mem_a_nx_s  = addr_r;
          mem_d_nx_s  = in_data;
          mem_we_nx_s = 1'b1;
          addr_nx_s   = addr_r + 1'b1;
          rem_nx_s    = rem_r - REM_ONE;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_nx_s   = csum_r + in_data;
`endif
        end else begin
          mem_we_nx_s = 1'b0;
        end
      end
      SETTLE: begin
        if (!mem_we_r) begin
          cnt_nx_s = cnt_r + 1'b1;
        end else begin
          cnt_nx_s = cnt_r;
        end
      end
      RUN: begin
        mem_we_nx_s = 1'b0;
      end
      default: begin
        mem_we_nx_s = 1'b0;
      end
    endcase
  end

  // Datapath and output registers; reset drops mem_we/mem_exec immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_r     <= '0;
      rem_r      <= '0;
      cnt_r      <= '0;
      mem_a_r    <= '0;
      mem_d_r    <= '0;
      mem_we_r   <= 1'b0;
      mem_exec_r <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_r     <= '0;
`endif
    end else begin
      addr_r     <= addr_nx_s;
      rem_r      <= rem_nx_s;
      cnt_r      <= cnt_nx_s;
      mem_a_r    <= mem_a_nx_s;
      mem_d_r    <= mem_d_nx_s;
      mem_we_r   <= mem_we_nx_s;
      mem_exec_r <= mem_exec_nx_s;
      done_r     <= done_nx_s;
      err_r      <= err_nx_s;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_r     <= csum_nx_s;
`endif
    end
  end

  assign in_ready = in_ready_s;
  assign busy     = (state_r != IDLE);
  assign mem_a    = mem_a_r;
  assign mem_d    = mem_d_r;
  assign mem_we   = mem_we_r;
  assign mem_exec = mem_exec_r;
  assign done     = done_r;
  assign err      = err_r;
`ifdef PROG_LOADER_CHECKSUM_EN
  assign checksum = csum_r;
`endif

endmodule : prog_loader

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: expected writes are queued when the
// host word is driven and compared when mem_we appears.
module tb_prog_loader;

  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load_req = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   word_count = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          halt = 1'b0;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_d;
  logic          mem_we;
  logic          mem_exec;
  logic          busy;
  logic          done;
  logic          err;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  prog_loader dut (
    .clk        (clk),
    .rst        (rst),
    .load_req   (load_req),
    .base_addr  (base_addr),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .halt       (halt),
    .mem_a      (mem_a),
    .mem_d      (mem_d),
    .mem_we     (mem_we),
    .mem_exec   (mem_exec),
    .busy       (busy),
    .done       (done),
    .err        (err)
`ifdef PROG_LOADER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           sb_q[$];
  logic [DW-1:0] fixed_q[$];
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  int            wr_cnt = 0;
  int            last_we_cyc = 0;
  int            exec_rise_cyc = 0;
  int            exec_rises = 0;
  int            done_cnt = 0;
  int            req_cyc = 0;
  logic          exec_prev = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Cycle counter.
  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor / scoreboard consumer.
  always @(negedge clk) begin
    if (rst) begin
      if (mem_we) begin
        wr_t e;
        wr_cnt++;
        last_we_cyc = cyc;
        check_eq("sb_nonempty", sb_q.size() > 0, 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check_eq("wr_addr", mem_a, e.a);
          check_eq("wr_data", mem_d, e.d);
        end
      end
      if (mem_exec && !exec_prev) begin
        exec_rises++;
        exec_rise_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        check_eq("done_with_exec", mem_exec, 1);
      end
      exec_prev = mem_exec;
    end else begin
      exec_prev = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [AW-1:0] b, input logic [AW:0] n);
    step();
    req_cyc    = cyc;
    load_req   = 1'b1;
    base_addr  = b;
    word_count = n;
    step();
    load_req   = 1'b0;
  endtask

  // Drive n words from address b; toggle inserts a stall every other cycle.
  task automatic send_words(input int n, input bit toggle, input logic [AW-1:0] b);
    int            sent = 0;
    int            guard = 0;
    logic [AW-1:0] a = b;
    while (sent < n && guard < 4 * n + 10) begin
      in_valid = toggle ? (guard % 2 == 0) : 1'b1;
      if (fixed_q.size() > 0 && in_valid) in_data = fixed_q.pop_front();
      else in_data = $urandom;
      @(negedge clk);
      check_eq("in_ready_load", in_ready, 1);
      if (in_valid) begin
        sb_q.push_back('{a: a, d: in_data});
        a++;
        sent++;
      end
      step();
      guard++;
    end
    in_valid = 1'b0;
    check_eq("send_complete", sent, n);
  endtask

  task automatic wait_exec(input int maxc);
    int k = 0;
    while (!mem_exec && k < maxc) begin
      step();
      k++;
    end
    check_eq("exec_within_bound", k < maxc, 1);
    @(negedge clk);
    #1;
  endtask

  task automatic do_halt();
    halt = 1'b1;
    step();
    halt = 1'b0;
  endtask

  initial begin
    int wr0, ex0, dn0;

    // Reset state.
    #12;
    check_eq("rst_outs", {mem_we, mem_exec, in_ready, busy, done, err}, 6'b0);
    check_eq("rst_mem_a", mem_a, 0);
    check_eq("rst_mem_d", mem_d, 0);
    @(negedge clk);
    rst = 1'b1;

    // 46 back-to-back words from address 0.
    dn0 = done_cnt;
    start_load(9'd0, 10'd46);
    check_eq("busy_load", busy, 1);
    wr0 = wr_cnt;
    send_words(46, 1'b0, 9'd0);
    wait_exec(20);
    check_eq("t1_writes", wr_cnt - wr0, 46);
    check_eq("t1_exec_lat", exec_rise_cyc - last_we_cyc, 3);
    check_eq("t1_done_once", done_cnt - dn0, 1);
    check_eq("t1_sb_empty", sb_q.size(), 0);

    // load_req during RUN is ignored.
    wr0 = wr_cnt;
    start_load(9'd5, 10'd3);
    repeat (4) step();
    check_eq("run_busy", busy, 1);
    check_eq("run_exec", mem_exec, 1);
    check_eq("run_no_writes", wr_cnt - wr0, 0);
    do_halt();
    check_eq("halt_exec_drop", mem_exec, 0);
    check_eq("halt_busy", busy, 0);
    check_eq("halt_done", done_cnt - dn0, 1);

    // Stalling host, base 13, 4 words.
    wr0 = wr_cnt;
    start_load(9'd13, 10'd4);
    send_words(4, 1'b1, 9'd13);
    wait_exec(20);
    check_eq("t2_writes", wr_cnt - wr0, 4);
    check_eq("t2_exec_lat", exec_rise_cyc - last_we_cyc, 3);
    do_halt();

    // Range error, then recovery.
    wr0 = wr_cnt;
    start_load(9'd510, 10'd3);
    check_eq("range_err", err, 1);
    check_eq("range_busy", busy, 0);
    repeat (3) step();
    check_eq("range_no_wr", wr_cnt - wr0, 0);
    start_load(9'd0, 10'd1);
    check_eq("range_err_clr", err, 0);
    check_eq("range_busy_again", busy, 1);
    send_words(1, 1'b0, 9'd0);
    wait_exec(20);
    check_eq("range_recover_wr", wr_cnt - wr0, 1);

    // Asynchronous reset in RUN drops exec without a clock edge.
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_eq("async_rst_exec", mem_exec, 0);
    check_eq("async_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;

    // Top-of-range load is legal: 511 + 1 == 2^AW.
    start_load(9'd511, 10'd1);
    check_eq("edge_range_ok", err, 0);
    send_words(1, 1'b0, 9'd511);
    wait_exec(20);
    do_halt();

    // halt on the third word of a 10-word load.
    wr0 = wr_cnt;
    ex0 = exec_rises;
    start_load(9'd100, 10'd10);
    send_words(2, 1'b0, 9'd100);
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    halt     = 1'b1;
    @(negedge clk);
    check_eq("halt_in_ready", in_ready, 0);
    step();
    halt     = 1'b0;
    in_valid = 1'b0;
    check_eq("halt_idle", busy, 0);
    repeat (10) step();
    check_eq("halt_writes", wr_cnt - wr0, 2);
    check_eq("halt_no_exec", exec_rises - ex0, 0);

    // Zero-count load: exec three cycles after load_req.
    wr0 = wr_cnt;
    start_load(9'd300, 10'd0);
    wait_exec(20);
    check_eq("zero_exec_lat", exec_rise_cyc - req_cyc, 3);
    check_eq("zero_no_wr", wr_cnt - wr0, 0);
    do_halt();

`ifdef PROG_LOADER_CHECKSUM_EN
    fixed_q.push_back(32'hFFFF_FFFF);
    fixed_q.push_back(32'h0000_0002);
    start_load(9'd200, 10'd2);
    send_words(2, 1'b0, 9'd200);
    wait_exec(20);
    check_eq("checksum", checksum, 32'h0000_0001);
    do_halt();
`endif

    check_eq("final_sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule : tb_prog_loader
